// File: rtl/adma_descriptor_store.sv
// Serialises one 96-bit ADMA descriptor into three 32-bit RAM writes at base, base+step, base+2*step.
// Optional readback verification is enabled by defining ADMA_DESC_STORE_VERIFY_EN.
module adma_descriptor_store #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned DESC_W    = 96
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [63:0]       address,
  input  logic [DESC_W-1:0] address_descriptor,
  output logic [63:0]       ram_address,
  output logic [31:0]       ram_data_out,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [31:0]       ram_data_in,
  output logic              busy,
  output logic              store_done,
  output logic              store_error
);

`ifdef ADMA_DESC_STORE_VERIFY_EN
  typedef enum logic [3:0] {IDLE, WR0, WR1, WR2, RD0, RD1, RD2, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, DONE} state_t;
`endif

  localparam logic [63:0] STEP1 = 64'(ADDR_STEP);
  localparam logic [63:0] STEP2 = 64'(2 * ADDR_STEP);

  state_t              state_q, state_d;
  logic [63:0]         base_q, base_d;
  logic [DESC_W-1:0]   desc_q, desc_d;
  logic [63:0]         ram_address_q, ram_address_d;
  logic [31:0]         ram_data_q, ram_data_d;
  logic                ram_write_q, ram_write_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef ADMA_DESC_STORE_VERIFY_EN
  logic                ram_read_q, ram_read_d;
  logic                error_q, error_d;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WR0;
      WR0:     state_d = WR1;
      WR1:     state_d = WR2;
`ifdef ADMA_DESC_STORE_VERIFY_EN
      WR2:     state_d = RD0;
      RD0:     state_d = RD1;
      RD1:     state_d = RD2;
      RD2:     state_d = CHK;
      CHK:     state_d = DONE;
`else
      WR2:     state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they appear registered in that state.
  always_comb begin
    base_d        = base_q;
    desc_d        = desc_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_write_d   = 1'b0;
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    case (state_d)
      WR0: begin
        base_d        = address;
        desc_d        = address_descriptor;
        ram_address_d = address;
        ram_data_d    = address_descriptor[31:0];
        ram_write_d   = 1'b1;
      end
      WR1: begin
        ram_address_d = base_q + STEP1;
        ram_data_d    = desc_q[63:32];
        ram_write_d   = 1'b1;
      end
      WR2: begin
        ram_address_d = base_q + STEP2;
        ram_data_d    = desc_q[95:64];
        ram_write_d   = 1'b1;
      end
`ifdef ADMA_DESC_STORE_VERIFY_EN
      RD0:     ram_address_d = base_q;
      RD1:     ram_address_d = base_q + STEP1;
      RD2:     ram_address_d = base_q + STEP2;
`endif
      default: ;
    endcase
  end

`ifdef ADMA_DESC_STORE_VERIFY_EN
  // Read data lags ram_read by one cycle, so each word is compared in the state after its read.
  always_comb begin
    ram_read_d = (state_d == RD0) || (state_d == RD1) || (state_d == RD2);
    error_d    = error_q;
    if (state_d == WR0) error_d = 1'b0;
    case (state_q)
      RD1:     if (ram_data_in != desc_q[31:0])  error_d = 1'b1;
      RD2:     if (ram_data_in != desc_q[63:32]) error_d = 1'b1;
      CHK:     if (ram_data_in != desc_q[95:64]) error_d = 1'b1;
      default: ;
    endcase
  end
`else
  logic unused_ram_data_in;
  assign unused_ram_data_in = ^ram_data_in;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      base_q        <= '0;
      desc_q        <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef ADMA_DESC_STORE_VERIFY_EN
      ram_read_q    <= 1'b0;
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      desc_q        <= desc_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_write_q   <= ram_write_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef ADMA_DESC_STORE_VERIFY_EN
      ram_read_q    <= ram_read_d;
      error_q       <= error_d;
`endif
    end
  end

  assign ram_address  = ram_address_q;
  assign ram_data_out = ram_data_q;
  assign ram_write    = ram_write_q;
  assign busy         = busy_q;
  assign store_done   = done_q;
`ifdef ADMA_DESC_STORE_VERIFY_EN
  assign ram_read     = ram_read_q;
  assign store_error  = error_q;
`else
  assign ram_read     = 1'b0;
  assign store_error  = 1'b0;
`endif

endmodule

// File: tb/tb_adma_descriptor_store.sv
// Randomised self-checking bench for adma_descriptor_store; expected bus activity is derived
// from the descriptor word order, address arithmetic and store latency.
module tb_adma_descriptor_store;

`ifdef ADMA_DESC_STORE_VERIFY_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif
  localparam logic [31:0] CORRUPT_MASK = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [63:0] address;
  logic [95:0] address_descriptor;
  logic [63:0] ram_address;
  logic [31:0] ram_data_out;
  logic        ram_write;
  logic        ram_read;
  logic [31:0] ram_data_in;
  logic        busy;
  logic        store_done;
  logic        store_error;

  int checks = 0;
  int errors = 0;
  bit last_err = 1'b0;

  adma_descriptor_store #(.ADDR_STEP(4), .DESC_W(96)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .start              (start),
    .address            (address),
    .address_descriptor (address_descriptor),
    .ram_address        (ram_address),
    .ram_data_out       (ram_data_out),
    .ram_write          (ram_write),
    .ram_read           (ram_read),
    .ram_data_in        (ram_data_in),
    .busy               (busy),
    .store_done         (store_done),
    .store_error        (store_error)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [95:0] d, input int k);
    return d[32*k +: 32];
  endfunction

  function automatic logic [63:0] addr_of(input logic [63:0] b, input int k);
    return b + 64'(4 * k);
  endfunction

  function automatic logic [95:0] rand_desc();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle wr",   64'(ram_write),   64'(0));
      check("idle rd",   64'(ram_read),    64'(0));
      check("idle busy", 64'(busy),        64'(0));
      check("idle done", 64'(store_done),  64'(0));
      check("idle err",  64'(store_error), 64'(last_err));
      address            = {$urandom, $urandom};
      address_descriptor = rand_desc();
    end
  endtask

  // Caller is at a negedge with the DUT idle; the task returns at the negedge of the idle cycle.
  task automatic store(input logic [63:0] base, input logic [95:0] desc,
                       input bit hold, input bit poke, input bit corrupt);
    bit bad;
    bad = corrupt && (LAT == 8);
    start = 1'b1;
    address = base;
    address_descriptor = desc;
    for (int c = 1; c <= LAT + 1; c++) begin
      int wi;
      bit rd;
      logic [31:0] w;
      @(negedge CLK);
      rd = (LAT == 8) && (c >= 4) && (c <= 6);
      wi = (c <= 3) ? c - 1 : (rd ? c - 4 : 2);
      check($sformatf("wr c%0d", c),   64'(ram_write),  64'(c <= 3));
      check($sformatf("rd c%0d", c),   64'(ram_read),   64'(rd));
      check($sformatf("addr c%0d", c), ram_address,     addr_of(base, wi));
      check($sformatf("data c%0d", c), 64'(ram_data_out), 64'(word_of(desc, (c <= 3) ? c - 1 : 2)));
      check($sformatf("busy c%0d", c), 64'(busy),       64'(c <= LAT));
      check($sformatf("done c%0d", c), 64'(store_done), 64'(c == LAT));
      if (c <= 3)
        check($sformatf("err c%0d", c), 64'(store_error), 64'(0));
      else if (c >= LAT)
        check($sformatf("err c%0d", c), 64'(store_error), 64'(bad));
      start              = hold || (poke && c == 2);
      address            = {$urandom, $urandom};
      address_descriptor = rand_desc();
      ram_data_in        = $urandom;
      if (LAT == 8 && c >= 5 && c <= 7) begin
        w = word_of(desc, c - 5);
        if (bad && c == 6) w = w ^ CORRUPT_MASK;
        ram_data_in = w;
      end
    end
    last_err = bad;
  endtask

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    address = '0;
    address_descriptor = '0;
    ram_data_in = '0;
    #12;
    check("rst wr",   64'(ram_write),    64'(0));
    check("rst rd",   64'(ram_read),     64'(0));
    check("rst busy", 64'(busy),         64'(0));
    check("rst done", 64'(store_done),   64'(0));
    check("rst err",  64'(store_error),  64'(0));
    check("rst addr", ram_address,       64'(0));
    check("rst data", 64'(ram_data_out), 64'(0));
    @(negedge CLK);
    RESET = 1'b0;
    idle(2);

    store(64'h1000, 96'hCAFEBABE_12345678_00400021, 1'b0, 1'b0, 1'b0);
    idle(1);
    store(64'hFFFF_FFFF_FFFF_FFFC, rand_desc(), 1'b0, 1'b0, 1'b0);
    idle(1);
    store(64'h0000_0000_0000_3000, rand_desc(), 1'b0, 1'b1, 1'b0);
    idle(3);

    // Abort in the middle of a store.
    start = 1'b1;
    address = 64'h2000;
    address_descriptor = 96'h11111111_22222222_33333333;
    @(negedge CLK);
    check("abort wr0",  64'(ram_write), 64'(1));
    check("abort a0",   ram_address,    64'h2000);
    start = 1'b0;
    @(negedge CLK);
    check("abort wr1",  64'(ram_write), 64'(1));
    check("abort a1",   ram_address,    64'h2004);
    RESET = 1'b1;
    #1;
    check("abort wr",   64'(ram_write),  64'(0));
    check("abort busy", 64'(busy),       64'(0));
    check("abort done", 64'(store_done), 64'(0));
    check("abort addr", ram_address,     64'(0));
    last_err = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    idle(4);
    store(64'h0000_0000_0000_4000, rand_desc(), 1'b0, 1'b0, 1'b0);
    idle(1);

    // start held high: back-to-back stores.
    store(64'h5000, rand_desc(), 1'b1, 1'b0, 1'b0);
    store(64'h6000, rand_desc(), 1'b1, 1'b0, 1'b0);
    store(64'h7000, rand_desc(), 1'b0, 1'b0, 1'b0);
    idle(1);

    // Corrupted readback then a clean store.
    store(64'h8000, rand_desc(), 1'b0, 1'b0, 1'b1);
    idle(2);
    store(64'h9000, rand_desc(), 1'b0, 1'b0, 1'b0);
    idle(1);

    for (int i = 0; i < 16; i++) begin
      logic [63:0] b;
      bit h;
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      h = (i != 15) && ($urandom_range(0, 2) == 0);
      store(b, rand_desc(), h, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      if (!h) idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adma_descriptor_store.md
Name: adma_descriptor_store

Overview:
- Write-side counterpart of the ADMA descriptor fetch path.
- Takes one 96-bit ADMA descriptor plus a 64-bit base address and serializes it into three consecutive 32-bit RAM writes.
- Word order matches what the fetch path reassembles.
- Sits between the descriptor-table builder, the host-side register interface and the shared descriptor RAM.

Parameters:
- ADDR_STEP, 4: address increment between consecutive 32-bit words (byte addressing).
- DESC_W, 96: descriptor width; fixed at 3 x 32. Any other value is unsupported.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous reset, active-high.
- start  input  1  request to store one descriptor; sampled only in IDLE.
- address  input  64  base address of descriptor slot.
- address_descriptor  input  96  descriptor to store; [31:0] attribute/length word, [95:32] data address.
- ram_address  output  64  RAM word address.
- ram_data_out  output  32  write data to RAM.
- ram_write  output  1  RAM write strobe, one cycle per word.
- ram_read  output  1  RAM read strobe (verify option only).
- ram_data_in  input  32  RAM read data (verify option only).
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- store_done  output  1  one-cycle completion pulse.
- store_error  output  1  readback mismatch flag (verify option only).

Behaviour:
- Reset: all outputs 0, FSM to IDLE, latched address and descriptor cleared. Reset asserted mid-operation aborts immediately. The word being strobed in that cycle may land. No further writes occur, and store_done is not pulsed.
- All outputs are registered.
- States: IDLE, WR0, WR1, WR2, DONE (VERIFY states: see option below).
- IDLE: start=1 latches address into base_q and address_descriptor into desc_q, then goes to WR0. In IDLE: busy=0, ram_write=0.
- WR0: ram_address=base_q, ram_data_out=desc_q[31:0], ram_write=1.
- WR1: ram_address=base_q+ADDR_STEP, ram_data_out=desc_q[63:32], ram_write=1.
- WR2: ram_address=base_q+2*ADDR_STEP, ram_data_out=desc_q[95:64], ram_write=1.
- DONE: store_done=1 for exactly one cycle, ram_write=0, then IDLE.
- Latency: start accepted at edge N; writes visible in cycles N+1..N+3; store_done in cycle N+4. Minimum spacing between accepted starts is 5 cycles.
- Address arithmetic is modulo 2^64. Base 0xFFFF_FFFF_FFFF_FFFC wraps to 0x0 and 0x4 on the second and third words.
- start while busy is ignored; inputs are not re-sampled. start held high through DONE is accepted again on the first IDLE cycle.
- Input changes after acceptance have no effect on the words written.
- Outside WR states, ram_address and ram_data_out hold their last values.

Optional Feature:
- Macro: ADMA_DESC_STORE_VERIFY_EN.
- Enabled:
  - After WR2, the FSM runs RD0, RD1, RD2. Each drives ram_read=1 at the matching word address.
  - ram_data_in is valid one cycle after each ram_read and is compared to the word written.
  - A final CHK state compares the third word before DONE.
  - Any mismatch sets store_error. store_error is sticky until the next accepted start, which clears it.
  - Latency becomes start to store_done = 8 cycles.
- Disabled:
  - ram_read and store_error are tied to 0; ram_data_in is ignored.
  - Latency is 4 cycles as above.

Test Plan:
- Reset, then start with address=0x1000, address_descriptor=0xCAFEBABE_12345678_00400021 -> writes 0x00400021@0x1000, 0x12345678@0x1004, 0xCAFEBABE@0x1008 in consecutive cycles; store_done pulses 4 cycles after start.
- Base 0xFFFF_FFFF_FFFF_FFFC -> ram_address sequence 0xFFFF_FFFF_FFFF_FFFC, 0x0, 0x4.
- Second start pulse (new descriptor) during WR1 -> ignored; only the first descriptor is written; busy stays high; exactly one store_done.
- RESET asserted during WR1 -> ram_write, busy and store_done drop to 0 immediately; no WR2 write; next start behaves normally.
- start held high continuously -> back-to-back stores every 5 cycles with the correct word order each time.
- VERIFY_EN: RAM model corrupts word1 on readback -> store_error=1 with store_done. Next clean store -> store_error cleared at acceptance and stays 0.
